// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix_op_* engines and the matrix_writer:
// metadata layout of a matrix slot and the writer state encoding.
package matrix_op_defs_pkg;

    localparam int unsigned MATRIX_METADATA_WORDS = 3;
    localparam int unsigned META_ROWS_MSB         = 31;
    localparam int unsigned META_COLS_MSB         = 23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_META  = 3'd1,
        ST_DATA  = 3'd2,
        ST_ZFILL = 3'd3,
        ST_DONE  = 3'd4
    } writer_state_e;

    // Metadata word 0: rows and cols in the top two bytes, low half reserved as zero.
    function automatic logic [31:0] pack_meta0(input logic [7:0] rows, input logic [7:0] cols);
        logic [31:0] w;
        w = 32'd0;
        w[META_ROWS_MSB -: 8] = rows;
        w[META_COLS_MSB -: 8] = cols;
        return w;
    endfunction

endpackage

// File: rtl/matrix_writer.sv
// Writes one result matrix (3 metadata words + row-major data) into a BRAM slot.
// Optional build macro MATRIX_WRITER_ZERO_FILL_EN zero-fills the unused tail of the slot.
module matrix_writer
    import matrix_op_defs_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 1024,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_request,
    output logic                  write_ready,
    input  logic [2:0]            matrix_id,
    input  logic [7:0]            actual_rows,
    input  logic [7:0]            actual_cols,
    input  logic [7:0]            matrix_name [0:7],
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  writer_ready,
    output logic                  write_done,
    output logic                  write_error,
    output logic                  bram_wr_en,
    output logic [ADDR_WIDTH-1:0] bram_wr_addr,
    output logic [DATA_WIDTH-1:0] bram_wr_data
);

    localparam logic [15:0] MAX_TOTAL_W = 16'(BLOCK_SIZE - MATRIX_METADATA_WORDS);
    localparam logic [15:0] META_W      = 16'(MATRIX_METADATA_WORDS);

    writer_state_e         state_r;
    writer_state_e         next_state_s;
    logic [2:0]            id_r;
    logic [7:0]            rows_r;
    logic [7:0]            cols_r;
    logic [7:0]            name_r [0:7];
    logic [15:0]           total_r;
    logic [15:0]           idx_r;
    logic [1:0]            meta_cnt_r;
    logic                  write_ready_r;
    logic                  writer_ready_r;
    logic                  write_done_r;
    logic                  write_error_r;
    logic                  bram_wr_en_r;
    logic [ADDR_WIDTH-1:0] bram_wr_addr_r;
    logic [DATA_WIDTH-1:0] bram_wr_data_r;

    logic [15:0]           total_in_s;
    logic                  reject_s;
    logic                  accept_s;
    logic                  beat_s;
    logic                  last_beat_s;
    logic [ADDR_WIDTH-1:0] base_s;
    logic [ADDR_WIDTH-1:0] data_addr_s;
    logic [DATA_WIDTH-1:0] meta_word_s;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
    localparam logic [15:0] LAST_OFF_W = 16'(BLOCK_SIZE - 1);
    logic                  fill_last_s;
    assign fill_last_s = ((META_W + idx_r) == LAST_OFF_W);
`endif

    assign total_in_s  = {8'd0, actual_rows} * {8'd0, actual_cols};
    assign reject_s    = (actual_rows == 8'd0) || (actual_cols == 8'd0) || (total_in_s > MAX_TOTAL_W);
    assign accept_s    = (state_r == ST_IDLE) && write_request && write_ready_r;
    assign beat_s      = (state_r == ST_DATA) && data_valid && writer_ready_r;
    assign last_beat_s = (idx_r == (total_r - 16'd1));
    assign base_s      = ADDR_WIDTH'(id_r) * ADDR_WIDTH'(BLOCK_SIZE);
    assign data_addr_s = base_s + ADDR_WIDTH'(META_W + idx_r);

    // Metadata word selected by the META phase counter.
    always_comb begin
        meta_word_s = '0;
        case (meta_cnt_r)
            2'd0:    meta_word_s = DATA_WIDTH'(pack_meta0(rows_r, cols_r));
            2'd1:    meta_word_s = DATA_WIDTH'({name_r[0], name_r[1], name_r[2], name_r[3]});
            2'd2:    meta_word_s = DATA_WIDTH'({name_r[4], name_r[5], name_r[6], name_r[7]});
            default: meta_word_s = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = reject_s ? ST_DONE : ST_META;
                else          next_state_s = ST_IDLE;
            end
            ST_META: begin
                if (meta_cnt_r == 2'd2) next_state_s = ST_DATA;
                else                    next_state_s = ST_META;
            end
            ST_DATA: begin
                if (beat_s && last_beat_s) begin
`ifdef MATRIX_WRITER_ZERO_FILL_EN
                    // A slot filled to the last word has no tail left to clear.
                    next_state_s = (total_r < MAX_TOTAL_W) ? ST_ZFILL : ST_DONE;
`else
                    next_state_s = ST_DONE;
`endif
                end else begin
                    next_state_s = ST_DATA;
                end
            end
`ifdef MATRIX_WRITER_ZERO_FILL_EN
            ST_ZFILL: begin
                if (fill_last_s) next_state_s = ST_DONE;
                else             next_state_s = ST_ZFILL;
            end
`endif
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Request latch, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r           <= 3'd0;
            rows_r         <= 8'd0;
            cols_r         <= 8'd0;
            for (int i = 0; i < 8; i++) name_r[i] <= 8'd0;
            total_r        <= 16'd0;
            idx_r          <= 16'd0;
            meta_cnt_r     <= 2'd0;
            write_ready_r  <= 1'b0;
            writer_ready_r <= 1'b0;
            write_done_r   <= 1'b0;
            write_error_r  <= 1'b0;
            bram_wr_en_r   <= 1'b0;
            bram_wr_addr_r <= '0;
            bram_wr_data_r <= '0;
        end else begin
            write_ready_r  <= (next_state_s == ST_IDLE);
            writer_ready_r <= (next_state_s == ST_DATA);
            write_done_r   <= (next_state_s == ST_DONE);
            // Only a rejected request goes straight from IDLE to DONE.
            write_error_r  <= (next_state_s == ST_DONE) && (state_r == ST_IDLE);
            bram_wr_en_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r      <= 16'd0;
                    meta_cnt_r <= 2'd0;
                    if (accept_s) begin
                        id_r    <= matrix_id;
                        rows_r  <= actual_rows;
                        cols_r  <= actual_cols;
                        for (int i = 0; i < 8; i++) name_r[i] <= matrix_name[i];
                        total_r <= total_in_s;
                    end
                end
                ST_META: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= base_s + ADDR_WIDTH'(meta_cnt_r);
                    bram_wr_data_r <= meta_word_s;
                    meta_cnt_r     <= meta_cnt_r + 2'd1;
                end
                ST_DATA: begin
                    if (beat_s) begin
                        bram_wr_en_r   <= 1'b1;
                        bram_wr_addr_r <= data_addr_s;
                        bram_wr_data_r <= data_in;
                        idx_r          <= idx_r + 16'd1;
                    end
                end
`ifdef MATRIX_WRITER_ZERO_FILL_EN
                ST_ZFILL: begin
                    bram_wr_en_r   <= 1'b1;
                    bram_wr_addr_r <= data_addr_s;
                    bram_wr_data_r <= '0;
                    idx_r          <= idx_r + 16'd1;
                end
`endif
                default: begin
                    meta_cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign write_ready  = write_ready_r;
    assign writer_ready = writer_ready_r;
    assign write_done   = write_done_r;
    assign write_error  = write_error_r;
    assign bram_wr_en   = bram_wr_en_r;
    assign bram_wr_addr = bram_wr_addr_r;
    assign bram_wr_data = bram_wr_data_r;

endmodule

// File: tb/tb_matrix_writer.sv
// Scoreboard bench for matrix_writer: stimulus pushes expected BRAM writes and
// done/error pulses; a negedge monitor pops and compares them.
module tb_matrix_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_request;
    logic        write_ready;
    logic [2:0]  matrix_id;
    logic [7:0]  actual_rows;
    logic [7:0]  actual_cols;
    logic [7:0]  matrix_name [0:7];
    logic [31:0] data_in;
    logic        data_valid;
    logic        writer_ready;
    logic        write_done;
    logic        write_error;
    logic        bram_wr_en;
    logic [13:0] bram_wr_addr;
    logic [31:0] bram_wr_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    bit  done_q[$];

    matrix_writer #(.BLOCK_SIZE(1024), .ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .write_request(write_request), .write_ready(write_ready),
        .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
        .matrix_name(matrix_name), .data_in(data_in), .data_valid(data_valid),
        .writer_ready(writer_ready), .write_done(write_done), .write_error(write_error),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every BRAM write and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        wr_t e;
        bit  ee;
        if (bram_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", bram_wr_addr, bram_wr_data);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", 64'(bram_wr_addr), 64'(e.addr));
                check("wr_data", 64'(bram_wr_data), 64'(e.data));
                if (e.cyc >= 0) check("wr_latency_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
        if (write_done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: write_done=1 with none expected");
            end else begin
                ee = done_q.pop_front();
                check("write_error", 64'(write_error), 64'(ee));
            end
        end else if (write_error !== 1'b0) begin
            checks++; errors++;
            $display("FAIL error_without_done: write_error=%b write_done=%b", write_error, write_done);
        end
    end

    task automatic do_write(input int id, input int rows, input int cols, input int dbase,
                            input bit gaps, input bit hold, input int rst_after);
        logic [7:0] nm [0:7];
        int  total, k, n, base;
        bit  reject, v;
        wr_t w;
        total  = rows * cols;
        reject = (rows == 0) || (cols == 0) || (total > 1021);
        base   = id * 1024;
        for (int i = 0; i < 8; i++) nm[i] = 8'(8'h41 + i + id);
        n = 0;
        while (write_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("write_ready_idle", 64'(write_ready), 64'd1);
        if (write_ready !== 1'b1) return;
        matrix_id     = 3'(id);
        actual_rows   = 8'(rows);
        actual_cols   = 8'(cols);
        for (int i = 0; i < 8; i++) matrix_name[i] = nm[i];
        write_request = 1'b1;
        data_valid    = 1'b0;
        if (reject) begin
            done_q.push_back(1'b1);
        end else begin
            w.cyc = -1;
            w.addr = base;     w.data = {8'(rows), 8'(cols), 16'h0000};  wr_q.push_back(w);
            w.addr = base + 1; w.data = {nm[0], nm[1], nm[2], nm[3]};    wr_q.push_back(w);
            w.addr = base + 2; w.data = {nm[4], nm[5], nm[6], nm[7]};    wr_q.push_back(w);
        end
        @(negedge clk);
        check("write_ready_dropped", 64'(write_ready), 64'd0);
        if (!reject) begin
            k = 0; n = 0; v = 1'b0;
            while (k < total && n < 4 * total + 20) begin
                if (rst_after >= 0 && k == rst_after + 1) break;
                v          = gaps ? ~v : 1'b1;
                data_valid = v;
                data_in    = 32'(dbase + k);
                if (v && writer_ready === 1'b1) begin
                    w.addr = base + 3 + k; w.data = 32'(dbase + k); w.cyc = cyc + 1;
                    wr_q.push_back(w);
                    k++;
                end
                @(negedge clk);
                n++;
            end
            data_valid = 1'b0;
            if (rst_after >= 0) begin
                write_request = 1'b0;
                rst_n = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("write_ready_in_reset", 64'(write_ready), 64'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                check("write_ready_after_release", 64'(write_ready), 64'd1);
                return;
            end
            check("beat_count", 64'(k), 64'(total));
            check("writer_ready_after_last", 64'(writer_ready), 64'd0);
`ifdef MATRIX_WRITER_ZERO_FILL_EN
            for (int a = base + 3 + total; a < base + 1024; a++) begin
                w.addr = a; w.data = 32'd0; w.cyc = -1;
                wr_q.push_back(w);
            end
`endif
            done_q.push_back(1'b0);
        end
        n = 0;
        while (write_done !== 1'b1 && n < 1200) begin @(negedge clk); n++; end
        check("write_done_seen", 64'(write_done), 64'd1);
        if (!hold) write_request = 1'b0;
        @(negedge clk);
        check("write_done_single", 64'(write_done), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; write_request = 1'b0; matrix_id = 3'd0;
        actual_rows = 8'd0; actual_cols = 8'd0; data_in = 32'd0; data_valid = 1'b0;
        for (int i = 0; i < 8; i++) matrix_name[i] = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_write_ready", 64'(write_ready), 64'd0);
        check("rst_writer_ready", 64'(writer_ready), 64'd0);
        check("rst_write_done", 64'(write_done), 64'd0);
        check("rst_bram_wr_en", 64'(bram_wr_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("write_ready_first_edge", 64'(write_ready), 64'd1);

        do_write(1, 3, 3, 1, 1'b0, 1'b0, -1);       // 3x3 to slot 1, data 1..9
        do_write(0, 8, 10, 32'h100, 1'b1, 1'b0, -1); // 8x10, valid toggling
        do_write(3, 0, 5, 0, 1'b0, 1'b0, -1);        // rows==0 rejected
        do_write(4, 32, 32, 0, 1'b0, 1'b0, -1);      // 1024 > 1021 rejected
        do_write(5, 4, 4, 32'hA0, 1'b0, 1'b0, 5);    // reset after beat 5
        do_write(6, 2, 3, 32'h200, 1'b0, 1'b0, -1);  // normal after reset
        do_write(2, 2, 2, 32'h300, 1'b0, 1'b1, -1);  // request held through done
        do_write(7, 3, 2, 32'h400, 1'b1, 1'b0, -1);
`ifdef MATRIX_WRITER_ZERO_FILL_EN
        do_write(2, 2, 2, 32'h500, 1'b0, 1'b0, -1);  // zero fill 2055..3071
`endif
        repeat (5) @(negedge clk);
        check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
        check("done_queue_drained", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
